// File: rtl/bgr_seq_pkg.sv
// bgr_seq_pkg: state encoding, default constants and width helper shared by
// the bandgap startup sequencer.
package bgr_seq_pkg;

    localparam int BGR_N_CH_DEF    = 2;
    localparam int BGR_TRIM_W_DEF  = 5;
    localparam int BGR_PORST_DEF   = 16;
    localparam int BGR_SETTLE_DEF  = 256;
    localparam int BGR_RETRY_DEF   = 2;

    // Mid-code of the default ladder width; the top recomputes it per TRIM_W.
    localparam logic [BGR_TRIM_W_DEF-1:0] BGR_TRIM_MID_DEF = 5'h10;

    // Fixed binary encoding kept stable for tools that decode the state bus.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PORST  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_CHECK  = 3'd3;
    localparam logic [2:0] S_READY  = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_PORST  = S_PORST,
        ST_SETTLE = S_SETTLE,
        ST_CHECK  = S_CHECK,
        ST_READY  = S_READY,
        ST_FAULT  = S_FAULT
    } bgr_state_t;

    // Bits needed to hold 0..v, never less than one.
    function automatic int bgr_cw(input int v);
        return (v < 1) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/bgr_sync2.sv
// bgr_sync2: plain two-flop synchronizer, W bits wide, synchronous reset to 0.
module bgr_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two back-to-back flops; only q is safe to use downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/bgr_startup_seq.sv
// bgr_startup_seq: startup pulse, trim, settle and window-check sequencer for
// N_CH bandgap cores, with retry and sticky fault reporting.
// Build option: define BGR_CMP_SYNC_EN to pass cmp_ok through a two-flop
// synchronizer (adds two cycles of comparator-to-decision latency).
module bgr_startup_seq
    import bgr_seq_pkg::*;
#(
    parameter int N_CH          = BGR_N_CH_DEF,
    parameter int TRIM_W        = BGR_TRIM_W_DEF,
    parameter int PORST_CYCLES  = BGR_PORST_DEF,
    parameter int SETTLE_CYCLES = BGR_SETTLE_DEF,
    parameter int MAX_RETRY     = BGR_RETRY_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     trim_load,
    input  logic [N_CH*TRIM_W-1:0]   trim_in,
    input  logic [N_CH-1:0]          cmp_ok,
    output logic                     porst,
    output logic [N_CH*TRIM_W-1:0]   trim_sel,
    output logic                     ready,
    output logic                     fault,
    output logic [N_CH-1:0]          fault_mask
);

    localparam int CW = bgr_cw((PORST_CYCLES > SETTLE_CYCLES) ? PORST_CYCLES : SETTLE_CYCLES);
    localparam int RW = bgr_cw(MAX_RETRY);

    localparam logic [CW-1:0]     PORST_LD  = CW'(PORST_CYCLES);
    localparam logic [CW-1:0]     SETTLE_LD = CW'(SETTLE_CYCLES);
    localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
    localparam logic [RW-1:0]     RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [TRIM_W-1:0] TRIM_MID  = TRIM_W'(1) << (TRIM_W - 1);

    bgr_state_t                    state, state_d;
    logic [CW-1:0]                 cnt, cnt_d;
    logic [RW-1:0]                 retry, retry_d;
    logic [N_CH-1:0]               mask_d;
    logic [N_CH-1:0][TRIM_W-1:0]   trim_q, trim_d;
    logic [N_CH-1:0]               cmp_use;
    logic                          all_ok;
    logic                          trim_acc;

`ifdef BGR_CMP_SYNC_EN
    bgr_sync2 #(.W(N_CH)) u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_ok),
        .q   (cmp_use)
    );
`else
    assign cmp_use = cmp_ok;
`endif

    assign all_ok   = &cmp_use;
    assign trim_acc = trim_load &&
                      (state == ST_IDLE || state == ST_READY || state == ST_FAULT);
    assign trim_sel = trim_q;

    // Next-state, counter, retry and trim decisions; en=0 overrides the FSM.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        retry_d = retry;
        mask_d  = fault_mask;
        trim_d  = trim_q;

        if (trim_acc)
            trim_d = trim_in;

        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_PORST;
                    cnt_d   = PORST_LD;
                    retry_d = '0;
                end
            end
            ST_PORST: begin
                if (cnt == CNT_ONE) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt == CNT_ONE) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt - CNT_ONE;
                end
            end
            ST_CHECK: begin
                if (all_ok) begin
                    state_d = ST_READY;
                    retry_d = '0;
                end else if (retry < RETRY_MAX) begin
                    state_d = ST_PORST;
                    cnt_d   = PORST_LD;
                    retry_d = retry + RW'(1);
                end else begin
                    state_d = ST_FAULT;
                    mask_d  = ~cmp_use;
                end
            end
            ST_READY: begin
                // Health loss wins over a simultaneous retrim: restart fully.
                if (!all_ok) begin
                    state_d = ST_PORST;
                    cnt_d   = PORST_LD;
                end else if (trim_load) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_LD;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            retry_d = '0;
            mask_d  = '0;
        end
    end

    // State, counters, trim codes and registered output decodes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            retry      <= '0;
            porst      <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
            fault_mask <= '0;
            for (int c = 0; c < N_CH; c++)
                trim_q[c] <= TRIM_MID;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            retry      <= retry_d;
            porst      <= (state_d == ST_PORST);
            ready      <= (state_d == ST_READY);
            fault      <= (state_d == ST_FAULT);
            fault_mask <= mask_d;
            trim_q     <= trim_d;
        end
    end

endmodule

// File: tb/tb_bgr_startup_seq.sv
// tb_bgr_startup_seq: directed plus randomized checks of the BGR sequencer
// against a timeline model built from attempt lengths.
module tb_bgr_startup_seq;

    localparam int N_CH = 2;
    localparam int TW   = 5;
    localparam int PC   = 4;
    localparam int SC   = 8;
    localparam int MR   = 2;
    localparam int ATT  = PC + SC + 1;

    logic       clk = 1'b0;
    logic       rst, en, trim_load;
    logic [9:0] trim_in, trim_sel;
    logic [1:0] cmp_ok, fault_mask;
    logic       porst, ready, fault;

    int         n_pass = 0;
    int         n_tot  = 0;
    int         n_fail = 0;
    logic [9:0] trim_exp;

    bgr_startup_seq #(
        .N_CH(N_CH), .TRIM_W(TW), .PORST_CYCLES(PC),
        .SETTLE_CYCLES(SC), .MAX_RETRY(MR)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .trim_load(trim_load),
        .trim_in(trim_in), .cmp_ok(cmp_ok), .porst(porst),
        .trim_sel(trim_sel), .ready(ready), .fault(fault),
        .fault_mask(fault_mask)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input bit p, input bit r,
                              input bit f, input logic [1:0] m);
        chk({tag, ".porst"},      32'(porst),      32'(p));
        chk({tag, ".ready"},      32'(ready),      32'(r));
        chk({tag, ".fault"},      32'(fault),      32'(f));
        chk({tag, ".fault_mask"}, 32'(fault_mask), 32'(m));
        chk({tag, ".trim_sel"},   32'(trim_sel),   32'(trim_exp));
    endtask

    task automatic reset_dut();
        rst = 1'b1; en = 1'b0; trim_load = 1'b0; trim_in = '0; cmp_ok = 2'b11;
        step();
        step();
        rst = 1'b0;
        step();
        trim_exp = 10'h210;
    endtask

    // Start from IDLE with en rising at cycle 0. Attempt a holds cmp_ok=pats[a];
    // every attempt is PC+SC+1 cycles long and the first all-ones pattern wins.
    task automatic run_seq(input string tag, input logic [1:0] p0,
                           input logic [1:0] p1, input logic [1:0] p2);
        logic [1:0] pats [3];
        int  n_att, endc, a;
        bit  pass, ep;
        pats  = '{p0, p1, p2};
        pass  = 1'b0;
        n_att = MR + 1;
        for (int i = 0; i <= MR; i++)
            if (!pass && pats[i] == 2'b11) begin
                pass  = 1'b1;
                n_att = i + 1;
            end
        endc   = ATT * n_att;
        en     = 1'b1;
        cmp_ok = pats[0];
        for (int c = 1; c <= endc + 2; c++) begin
            step();
            ep = (c <= endc) && (((c - 1) % ATT) < PC);
            check_outs(tag, ep, pass && c > endc, !pass && c > endc,
                       (!pass && c > endc) ? ~pats[MR] : 2'b00);
            a = (c - 1) / ATT;
            if (a > MR) a = MR;
            cmp_ok = (pass && a >= n_att - 1) ? 2'b11 : pats[a];
        end
    endtask

    initial begin
        // Reset values
        reset_dut();
        check_outs("reset", 1'b0, 1'b0, 1'b0, 2'b00);
        chk("reset.mid_code", 32'(trim_sel), 32'h210);

        // Nominal start, then retrim in READY
        run_seq("nominal", 2'b11, 2'b11, 2'b11);
        trim_in = 10'h26A; trim_load = 1'b1;
        step();
        trim_load = 1'b0;
        trim_exp  = 10'h26A;
        for (int k = 1; k <= SC + 2; k++) begin
            if (k > 1) step();
            check_outs("retrim", 1'b0, k == SC + 2, 1'b0, 2'b00);
        end

        // Health loss in READY, restored on the next cycle
        cmp_ok = 2'b10;
        for (int c = 1; c <= ATT + 2; c++) begin
            step();
            check_outs("health", c <= PC, c > ATT, 1'b0, 2'b00);
            cmp_ok = 2'b11;
        end

        // trim_load together with en=0 in READY: load applies, block goes IDLE
        trim_in = 10'($urandom); trim_load = 1'b1; en = 1'b0;
        step();
        trim_load = 1'b0;
        trim_exp  = trim_in;
        check_outs("load_off", 1'b0, 1'b0, 1'b0, 2'b00);
        en = 1'b1;
        step();
        chk("load_off.restart", 32'(porst), 32'd1);
        en = 1'b0;
        step();

        // Exhausted retries, then en=0 clears the fault
        reset_dut();
        run_seq("retry", 2'b01, 2'b01, 2'b01);
        en = 1'b0;
        step();
        check_outs("fault_clr", 1'b0, 1'b0, 1'b0, 2'b00);

        // Abort during PORST; trim_load ignored there
        en = 1'b1;
        step();
        chk("abort.c1", 32'(porst), 32'd1);
        trim_in = 10'($urandom); trim_load = 1'b1;
        step();
        trim_load = 1'b0;
        check_outs("abort.c2", 1'b1, 1'b0, 1'b0, 2'b00);
        en = 1'b0;
        step();
        check_outs("abort.c3", 1'b0, 1'b0, 1'b0, 2'b00);
        step();
        run_seq("reenable", 2'b11, 2'b11, 2'b11);
        en = 1'b0;
        step();

        // Reset mid-SETTLE after a non-default trim
        trim_in = 10'h26A; trim_load = 1'b1;
        step();
        trim_load = 1'b0;
        trim_exp  = 10'h26A;
        chk("idle_load", 32'(trim_sel), 32'h26A);
        en = 1'b1; cmp_ok = 2'b11;
        for (int c = 1; c <= 7; c++) begin
            step();
            chk("pre_rst.porst", 32'(porst), 32'(c <= PC));
        end
        rst = 1'b1;
        step();
        trim_exp = 10'h210;
        check_outs("mid_rst", 1'b0, 1'b0, 1'b0, 2'b00);
        rst = 1'b0; en = 1'b0;
        step();

        // Randomized attempts with random trim codes loaded in IDLE
        for (int t = 0; t < 6; t++) begin
            trim_in = 10'($urandom); trim_load = 1'b1;
            step();
            trim_load = 1'b0;
            trim_exp  = trim_in;
            run_seq("rand", 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)));
            en = 1'b0;
            step();
            check_outs("rand_off", 1'b0, 1'b0, 1'b0, 2'b00);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
